// File: rtl/nes_pad_reader.sv
// nes_pad_reader
// Polls an NES-style serial gamepad (4021 parallel-in shift register) and
// presents a registered, active-high 8-button word to game logic.
//
// A read frame starts on request or automatically once per poll period.
// Each frame pulses pad_latch, then clocks out the remaining seven bits.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request an immediate read (honoured only when idle)
//   pad_data  in   serial data from pad, active-low, asynchronous
//   pad_latch out  parallel-load strobe to pad, active-high
//   pad_clk   out  shift clock to pad
//   buttons   out  [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//   valid     out  one-cycle pulse when buttons has just updated
//   busy      out  high while a read frame is in progress
module nes_pad_reader #(
  parameter int CLK_DIV  = 150,
  parameter int POLL_DIV = 416667
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       busy
);

  localparam int DIV_W  = $clog2(2 * CLK_DIV);
  localparam int POLL_W = $clog2(POLL_DIV);

  localparam logic [DIV_W-1:0]  LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  HALF_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_HI,
    CLK_LO,
    DONE
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [POLL_W-1:0] poll_cnt;
  logic [2:0]        bit_idx;
  logic [6:0]        shreg;
  logic              sync_meta;
  logic              sync_data;
  logic              poll_req;

  // Two-flop synchroniser; resets to the released (high) level so a
  // reset never looks like a pressed button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b1;
      sync_data <= 1'b1;
    end else begin
      sync_meta <= pad_data;
      sync_data <= sync_meta;
    end
  end

  // Free-running poll period counter, independent of the frame state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_cnt <= '0;
    end else if (poll_cnt == POLL_LAST) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  assign poll_req = (poll_cnt == POLL_LAST);

  // Frame sequencer. Every output is a flop updated on the state
  // transition, so pad_latch/pad_clk never glitch on state decoding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_idx   <= 3'd0;
      shreg     <= '0;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      buttons   <= 8'h00;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start || poll_req) begin
            state     <= LATCH;
            pad_latch <= 1'b1;
            busy      <= 1'b1;
            div_cnt   <= '0;
            bit_idx   <= 3'd1;
            shreg     <= '0;
          end
        end

        LATCH: begin
          if (div_cnt == LATCH_LAST) begin
            // While latched the pad already presents button A.
            shreg[0]  <= ~sync_data;
            state     <= CLK_HI;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b1;
            div_cnt   <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        CLK_HI: begin
          if (div_cnt == HALF_LAST) begin
            state   <= CLK_LO;
            pad_clk <= 1'b0;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        CLK_LO: begin
          if (div_cnt == HALF_LAST) begin
            div_cnt <= '0;
            if (bit_idx == 3'd7) begin
              // Final bit goes straight into the output word so buttons
              // and valid appear together in DONE.
              buttons <= {~sync_data, shreg};
              valid   <= 1'b1;
              state   <= DONE;
            end else begin
              shreg[bit_idx] <= ~sync_data;
              bit_idx        <= bit_idx + 3'd1;
              pad_clk        <= 1'b1;
              state          <= CLK_HI;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          pad_latch <= 1'b0;
          pad_clk   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader
// Directed bench for nes_pad_reader with CLK_DIV=4, POLL_DIV=100 and a
// behavioural 4021 pad model. A negedge monitor measures strobe widths,
// pulse counts, busy length and valid timing; directed tasks compare them
// against hand-computed values.
module tb_nes_pad_reader;

  localparam int CLK_DIV  = 4;
  localparam int POLL_DIV = 100;
  localparam int FRAME    = 16 * CLK_DIV + 1;  // 65

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic       valid;
  logic       busy;

  nes_pad_reader #(.CLK_DIV(CLK_DIV), .POLL_DIV(POLL_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons),
    .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 4021 pad model ----------------
  // mode 0: shift register, 1: data stuck low, 2: data stuck high
  logic [7:0] pressed;
  logic [1:0] mode;
  logic [7:0] sr = 8'hFF;
  logic       pclk_d = 1'b0;

  always @(posedge clk) begin
    pclk_d <= pad_clk;
    if (pad_latch) sr <= ~pressed;
    else if (pad_clk && !pclk_d) sr <= {1'b1, sr[7:1]};
  end

  assign pad_data = (mode == 2'd1) ? 1'b0 : (mode == 2'd2) ? 1'b1 : sr[0];

  // ---------------- monitor ----------------
  int latch_run = 0, last_latch_len = 0, latch_frames = 0;
  int busy_run = 0, last_busy_len = 0;
  int hi_run = 0, lo_run = 0, pclk_rises = 0, width_err = 0;
  int valid_count = 0, last_valid_cyc = 0, prev_valid_cyc = 0;
  logic latch_prev = 1'b0, busy_prev = 1'b0, pclk_prev = 1'b0, lo_armed = 1'b0;

  always @(negedge clk) begin
    latch_prev <= pad_latch;
    busy_prev  <= busy;
    pclk_prev  <= pad_clk;

    if (pad_latch) latch_run <= latch_run + 1;
    else if (latch_prev) begin
      last_latch_len <= latch_run;
      latch_run      <= 0;
      latch_frames   <= latch_frames + 1;
    end

    if (busy) busy_run <= busy_run + 1;
    else if (busy_prev) begin
      last_busy_len <= busy_run;
      busy_run      <= 0;
    end

    if (pad_clk) begin
      hi_run <= hi_run + 1;
      if (!pclk_prev) begin
        pclk_rises <= pclk_rises + 1;
        if (lo_armed && lo_run != CLK_DIV) width_err <= width_err + 1;
      end
    end else if (pclk_prev) begin
      if (hi_run != CLK_DIV) width_err <= width_err + 1;
      hi_run   <= 0;
      lo_run   <= 1;
      lo_armed <= 1'b1;
    end else begin
      lo_run <= lo_run + 1;
    end
    if (pad_latch) lo_armed <= 1'b0;

    if (valid) begin
      valid_count    <= valid_count + 1;
      last_valid_cyc <= cyc;
      prev_valid_cyc <= last_valid_cyc;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(output int t);
    @(negedge clk);
    start = 1'b1;
    t = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int t);
    bit got = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (got) check({tag, "_lat"}, 32'(cyc - t), 32'(FRAME));
    else     check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] p, input logic [1:0] m,
                           input logic [7:0] exp, input bit do_rst);
    int t, v0, l0, r0, w0;
    pressed = p;
    mode = m;
    if (do_rst) apply_reset();
    repeat (2) @(negedge clk);
    v0 = valid_count; l0 = latch_frames; r0 = pclk_rises; w0 = width_err;
    pulse_start(t);
    wait_valid(tag, t);
    check({tag, "_buttons"}, 32'(buttons), 32'(exp));
    repeat (4) @(negedge clk);
    check({tag, "_valids"}, 32'(valid_count - v0), 32'd1);
    check({tag, "_latch_len"}, 32'(last_latch_len), 32'(2 * CLK_DIV));
    check({tag, "_latches"}, 32'(latch_frames - l0), 32'd1);
    check({tag, "_pulses"}, 32'(pclk_rises - r0), 32'd7);
    check({tag, "_width_err"}, 32'(width_err - w0), 32'd0);
    check({tag, "_busy_len"}, 32'(last_busy_len), 32'(FRAME));
    $display("frame %s pressed=%02h buttons=%02h", tag, p, buttons);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, t2, v0, l0;
    rst_n = 1'b1; start = 1'b0; pressed = 8'h00; mode = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    check("rst0_latch", 32'(pad_latch), 32'd0);
    check("rst0_pclk", 32'(pad_clk), 32'd0);
    check("rst0_buttons", 32'(buttons), 32'd0);
    check("rst0_valid", 32'(valid), 32'd0);
    check("rst0_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");

    // Pattern read
    run_frame("a5", 8'hA5, 2'd0, 8'hA5, 1'b1);

    // Asynchronous reset during the 4th pad_clk pulse
    pressed = 8'hFF;
    pulse_start(t);
    repeat (33) @(negedge clk);
    check("mid_pclk_hi", 32'(pad_clk), 32'd1);
    check("mid_busy_hi", 32'(busy), 32'd1);
    v0 = valid_count;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_latch", 32'(pad_latch), 32'd0);
    check("mid_rst_pclk", 32'(pad_clk), 32'd0);
    check("mid_rst_buttons", 32'(buttons), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("mid_no_valid", 32'(valid_count - v0), 32'd0);
    check("mid_buttons_hold", 32'(buttons), 32'd0);
    $display("reset mid-shift done");
    run_frame("ff_after", 8'hFF, 2'd0, 8'hFF, 1'b0);

    // Extremes and bit order
    run_frame("all_low", 8'h00, 2'd1, 8'hFF, 1'b1);
    run_frame("unplug", 8'hA5, 2'd2, 8'h00, 1'b1);
    run_frame("b01", 8'h01, 2'd0, 8'h01, 1'b1);
    run_frame("b80", 8'h80, 2'd0, 8'h80, 1'b1);

    // Start ignored while busy
    pressed = 8'h5A; mode = 2'd0;
    apply_reset();
    repeat (2) @(negedge clk);
    v0 = valid_count; l0 = latch_frames;
    pulse_start(t);
    repeat (8) @(negedge clk);
    pulse_start(t2);
    check("ign_start_offset", 32'(t2 - t), 32'd10);
    wait_valid("ign", t);
    check("ign_buttons", 32'(buttons), 32'h5A);
    repeat (20) @(negedge clk);
    check("ign_valids", 32'(valid_count - v0), 32'd1);
    check("ign_latches", 32'(latch_frames - l0), 32'd1);
    $display("busy ignore done");

    // Autopoll with start held low
    pressed = 8'h3C;
    apply_reset();
    v0 = valid_count; l0 = latch_frames;
    repeat (400) @(negedge clk);
    check("poll_valids", 32'(valid_count - v0), 32'd3);
    check("poll_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'(POLL_DIV));
    check("poll_busy_len", 32'(last_busy_len), 32'(FRAME));
    check("poll_buttons", 32'(buttons), 32'h3C);
    $display("autopoll valids=%0d spacing=%0d", valid_count - v0, last_valid_cyc - prev_valid_cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
